timer_share_arbiter: RTL and testbench
======================================

// Module: timer_share_arbiter
// PURPOSE
//  Shares one TIMER_BAMSE instance among NREQ requesters.
//  Arbitrates round-robin and programs the timer through its register port (address/config_in/wen/ren).
//  Waits for the timer interrupt, then stops and clears the timer and returns a done pulse to the winner.
//  Sits between requester logic and the timer, in place of direct processor writes.
// PARAMETERS
//  NREQ      4        number of requesters (2..8)
//  TMR_ADDR  8'h00    register address of the shared timer (matches its ADDR)
//  TIMEOUT   16'hFFFF WAIT-state cycle limit (used only with TSA_TIMEOUT_EN)
// PORTS
//  clk            in   1        system clock, rising edge
//  rst            in   1        asynchronous reset, active-low
//  req            in   NREQ     level request; hold high until done/err
//  req_load       in   NREQ*16  per-requester timer_conf value; slice i = [16i+15:16i]
//  req_presc      in   NREQ*3   per-requester prescaler select; slice i = [3i+2:3i]
//  grant          out  NREQ     one-hot owner of the timer
//  done           out  NREQ     1-cycle pulse to owner on timer expiry
//  err            out  1        1-cycle abort pulse (TSA_TIMEOUT_EN only; else tied 0)
//  tmr_address    out  8        always TMR_ADDR
//  tmr_timer_conf out  16       load value to timer
//  tmr_config_in  out  8        {1'b0,presc[2:0],auto_load,en,go,int}
//  tmr_wen        out  1        timer register write strobe
//  tmr_ren        out  1        timer register read strobe
//  tmr_config_out in   8        timer status; bit0 = interrupt
// BEHAVIOUR
//  - Reset (rst=0): state=INIT; grant=0, done=0, err=0, wen=0, ren=0.
//    Also config_in=0, timer_conf=0, rr pointer=0 (req[0] has highest priority).
//  - INIT: one cycle wen=1 with config_in=8'h00 (stops timer) -> IDLE.
//    Same behaviour when reset is released mid-operation.
//  - IDLE: if |req, pick the first set bit starting at ptr (wrapping), register grant -> LOAD; else stay.
//  - LOAD (1 cycle): wen=1, timer_conf=req_load[w], config_in={0,req_presc[w],0,1,1,0} -> WAIT.
//    auto_load is never set.
//  - WAIT: ren=1 every cycle.
//    If config_out[0]=1 while ren=1 -> CLEAR with expiry flag set.
//    Else if req[w]=0 (cancel) -> CLEAR with expiry flag clear.
//    If both occur in the same cycle, expiry wins.
//  - CLEAR (1 cycle): wen=1, config_in=8'h00 (en=go=int=0) -> DONE.
//  - DONE (1 cycle): if the expiry flag is set, done[w]=1; grant->0; ptr=w+1 mod NREQ -> IDLE.
//  - Latency: req seen in IDLE at edge k gives grant at k+1 and wen at k+1..k+2 (LOAD).
//    Interrupt sampled at edge m gives CLEAR wen in m..m+1 and done in m+1..m+2.
//  - A requester still holding req after done re-enters arbitration at lowest priority; no back-to-back starvation.
//  - Requests arriving outside IDLE wait; no queueing beyond the req level.
//  - wen and ren are never high together; grant is never multi-hot; at most one done bit per cycle.
// CONFIGURATION
//  TSA_TIMEOUT_EN defined:
//   - 16-bit counter cleared on LOAD, incremented in WAIT.
//   - count==TIMEOUT with no interrupt -> CLEAR, then DONE with err=1 and done=0.
//  TSA_TIMEOUT_EN undefined:
//   - No counter; err tied 0; WAIT lasts until interrupt or cancel.
// TESTING
//  1. Reset: rst=0 then 1 -> one wen with config_in=00, then idle, all outputs 0.
//  2. Single request: req=0001, load=16'hFFF0, presc=3'b001 -> grant=0001; one wen with config_in=8'h16.
//     Interrupt -> wen with 8'h00, done=0001 for 1 cycle, grant=0.
//  3. Round-robin: req=1111 held -> grant order 0001,0010,0100,1000,0001.
//     Each grant shows its own load/presc on the timer outputs.
//  4. Cancel: req[2] drops in WAIT -> CLEAR write 8'h00, no done pulse, next requester granted.
//  5. Collision: interrupt and req drop in the same cycle -> done asserted (expiry wins).
//  6. TSA_TIMEOUT_EN, TIMEOUT=16'd20, interrupt withheld -> CLEAR after 20 WAIT cycles, err=1, done=0.
//  Also: reset asserted in WAIT -> outputs 0 immediately; INIT clear write follows release.

Source files
------------

// File: rtl/timer_share_arbiter.sv
// timer_share_arbiter
//   Shares one timer among NREQ requesters. A round-robin arbiter picks a
//   winner, programs the timer through its register port, waits for the
//   timer interrupt (or a cancel), stops/clears the timer, then pulses done
//   to the winner.
//
//   Optional feature macro: TSA_TIMEOUT_EN
//     defined   : WAIT is bounded by a 16-bit counter; on reaching TIMEOUT the
//                 timer is cleared and err pulses instead of done.
//     undefined : no counter, err tied 0.
//
//   Ports
//     clk, rst               clock (rising), async active-low reset
//     req[NREQ]              level requests, held until done/err
//     req_load[NREQ*16]      per-requester timer load value
//     req_presc[NREQ*3]      per-requester prescaler select
//     grant[NREQ]            one-hot current owner
//     done[NREQ]             1-cycle expiry pulse to the owner
//     err                    1-cycle timeout abort pulse
//     tmr_address            constant TMR_ADDR
//     tmr_timer_conf         load value presented to the timer
//     tmr_config_in          {0,presc,auto_load,en,go,int}
//     tmr_wen / tmr_ren      timer register write / read strobes
//     tmr_config_out         timer status, bit0 = interrupt
module timer_share_arbiter #(
  parameter int          NREQ     = 4,
  parameter logic [7:0]  TMR_ADDR = 8'h00,
  parameter logic [15:0] TIMEOUT  = 16'hFFFF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*16-1:0]   req_load,
  input  logic [NREQ*3-1:0]    req_presc,
  output logic [NREQ-1:0]      grant,
  output logic [NREQ-1:0]      done,
  output logic                 err,
  output logic [7:0]           tmr_address,
  output logic [15:0]          tmr_timer_conf,
  output logic [7:0]           tmr_config_in,
  output logic                 tmr_wen,
  output logic                 tmr_ren,
  input  logic [7:0]           tmr_config_out
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  localparam logic [2:0] S_INIT  = 3'd0;
  localparam logic [2:0] S_IDLE  = 3'd1;
  localparam logic [2:0] S_LOAD  = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_CLEAR = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  logic [2:0]    state;
  logic [PW-1:0] ptr, win;
  logic [15:0]   conf_r;
  logic [2:0]    presc_r;
  logic          exp_f;   // WAIT ended by interrupt (vs cancel/timeout)

  // Round-robin pick: first set req bit at or after ptr, wrapping.
  logic [PW-1:0] pick;
  logic          found;
  int            idx;

  always_comb begin
    pick  = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < NREQ; i++) begin
      idx = (int'(ptr) + i) % NREQ;
      if (!found && req[PW'(idx)]) begin
        found = 1'b1;
        pick  = PW'(idx);
      end
    end
  end

  logic irq;
  assign irq = tmr_config_out[0];

`ifdef TSA_TIMEOUT_EN
  logic [15:0] cnt;
  logic [15:0] cnt_nxt;
  logic        to_f;
  assign cnt_nxt = cnt + 16'd1;
  logic unused_cfg;
  assign unused_cfg = ^tmr_config_out[7:1];
`else
  logic unused_cfg;
  assign unused_cfg = ^{tmr_config_out[7:1], TIMEOUT};
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_INIT;
      grant   <= '0;
      ptr     <= '0;
      win     <= '0;
      conf_r  <= '0;
      presc_r <= '0;
      exp_f   <= 1'b0;
`ifdef TSA_TIMEOUT_EN
      cnt     <= '0;
      to_f    <= 1'b0;
`endif
    end else begin
      case (state)
        S_INIT: state <= S_IDLE;
        S_IDLE: begin
          if (found) begin
            grant   <= NREQ'(1) << pick;
            win     <= pick;
            conf_r  <= req_load[16*pick +: 16];
            presc_r <= req_presc[3*pick +: 3];
            state   <= S_LOAD;
          end
        end
        S_LOAD: begin
`ifdef TSA_TIMEOUT_EN
          cnt   <= '0;
`endif
          state <= S_WAIT;
        end
        S_WAIT: begin
          // Interrupt has priority over a simultaneous cancel.
          if (irq) begin
            exp_f <= 1'b1;
            state <= S_CLEAR;
          end else if (!req[win]) begin
            exp_f <= 1'b0;
            state <= S_CLEAR;
          end
`ifdef TSA_TIMEOUT_EN
          else if (cnt_nxt == TIMEOUT) begin
            exp_f <= 1'b0;
            to_f  <= 1'b1;
            state <= S_CLEAR;
          end else begin
            cnt <= cnt_nxt;
          end
`endif
        end
        S_CLEAR: state <= S_DONE;
        S_DONE: begin
          grant <= '0;
          exp_f <= 1'b0;
`ifdef TSA_TIMEOUT_EN
          to_f  <= 1'b0;
`endif
          // Winner drops to lowest priority for the next round.
          ptr   <= (win == PW'(NREQ-1)) ? '0 : win + 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_INIT;
      endcase
    end
  end

  // INIT is the reset state; gate its write strobe so wen stays low while
  // reset is held and the stop write happens in the first cycle after release.
  assign tmr_wen        = rst & ((state == S_INIT) | (state == S_LOAD) | (state == S_CLEAR));
  assign tmr_ren        = (state == S_WAIT);
  assign tmr_address    = TMR_ADDR;
  assign tmr_timer_conf = conf_r;
  // {0, presc, auto_load=0, en=1, go=1, int=0}
  assign tmr_config_in  = (state == S_LOAD) ? {1'b0, presc_r, 4'b0110} : 8'h00;
  assign done           = (state == S_DONE && exp_f) ? grant : '0;
`ifdef TSA_TIMEOUT_EN
  assign err            = (state == S_DONE) & to_f;
`else
  assign err            = 1'b0;
`endif

endmodule

// File: tb/tb_timer_share_arbiter.sv
// Scoreboard bench for timer_share_arbiter: expected timer programming and
// done pulses are queued as requests are driven, and checked when the DUT
// writes the timer or pulses done.
module tb_timer_share_arbiter;

  localparam int NREQ = 4;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic [NREQ-1:0]      req = '0;
  logic [NREQ*16-1:0]   req_load = '0;
  logic [NREQ*3-1:0]    req_presc = '0;
  logic [NREQ-1:0]      grant, done;
  logic                 err;
  logic [7:0]           tmr_address;
  logic [15:0]          tmr_timer_conf;
  logic [7:0]           tmr_config_in;
  logic                 tmr_wen, tmr_ren;
  logic [7:0]           tmr_config_out = 8'h00;

  timer_share_arbiter #(.NREQ(NREQ), .TMR_ADDR(8'h00), .TIMEOUT(16'd20)) dut (
    .clk(clk), .rst(rst), .req(req), .req_load(req_load), .req_presc(req_presc),
    .grant(grant), .done(done), .err(err), .tmr_address(tmr_address),
    .tmr_timer_conf(tmr_timer_conf), .tmr_config_in(tmr_config_in),
    .tmr_wen(tmr_wen), .tmr_ren(tmr_ren), .tmr_config_out(tmr_config_out));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NREQ-1:0] g;
    logic [15:0]     conf;
    logic [7:0]      cfg;
  } ld_t;

  ld_t             ld_q[$];
  logic [NREQ-1:0] dn_q[$];
  ld_t             e;
  int              n_tot = 0;
  int              n_bad = 0;
  int              n_clr = 0;
  int              clr_exp = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  function automatic logic [7:0] mk_cfg(input logic [2:0] p);
    return {1'b0, p, 1'b0, 1'b1, 1'b1, 1'b0};
  endfunction

  task automatic set_req_cfg(input int i, input logic [15:0] c, input logic [2:0] p);
    req_load[16*i +: 16] = c;
    req_presc[3*i +: 3]  = p;
  endtask

  task automatic push_ld(input int i, input logic [15:0] c, input logic [2:0] p);
    ld_t t;
    t.g    = NREQ'(1) << i;
    t.conf = c;
    t.cfg  = mk_cfg(p);
    ld_q.push_back(t);
  endtask

  task automatic wait_ren();
    int n = 0;
    while (!tmr_ren && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("ren_seen", tmr_ren, 1);
  endtask

  task automatic wait_done();
    int n = 0;
    while (done == '0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", done != '0, 1);
  endtask

  task automatic pulse_int();
    tmr_config_out = 8'h01;
    @(negedge clk);
    tmr_config_out = 8'h00;
  endtask

  // Monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (rst) begin
      chk("wen_ren_excl", tmr_wen & tmr_ren, 0);
      chk("grant_onehot", $countones(grant) <= 1, 1);
      if (tmr_wen && tmr_config_in != 8'h00) begin
        chk("ld_avail", ld_q.size() > 0, 1);
        if (ld_q.size() > 0) begin
          e = ld_q.pop_front();
          chk("ld_grant", grant, e.g);
          chk("ld_conf", tmr_timer_conf, e.conf);
          chk("ld_cfg", tmr_config_in, e.cfg);
        end
      end
      if (tmr_wen && tmr_config_in == 8'h00 && grant != '0) n_clr++;
      if (done != '0) begin
        chk("dn_avail", dn_q.size() > 0, 1);
        if (dn_q.size() > 0) chk("done_val", done, dn_q.pop_front());
      end
`ifndef TSA_TIMEOUT_EN
      chk("err_zero", err, 0);
`endif
    end
  end

  logic [15:0] rr_load [NREQ];
  logic [2:0]  rr_presc[NREQ];
  int          wcnt;

  initial begin
    rr_load  = '{16'h1234, 16'h2345, 16'h3456, 16'h4567};
    rr_presc = '{3'd3, 3'd5, 3'd7, 3'd2};

    // 1. reset state and INIT stop write
    repeat (2) @(negedge clk);
    chk("rst_grant", grant, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_wen", tmr_wen, 0);
    chk("rst_ren", tmr_ren, 0);
    chk("rst_cfg", tmr_config_in, 0);
    chk("rst_conf", tmr_timer_conf, 0);
    rst = 1'b1;
    #1;
    chk("init_wen", tmr_wen, 1);
    chk("init_cfg", tmr_config_in, 8'h00);
    chk("addr", tmr_address, 8'h00);
    @(negedge clk);
    chk("idle_wen", tmr_wen, 0);
    chk("idle_ren", tmr_ren, 0);
    @(negedge clk);

    // 2. single request
    set_req_cfg(0, 16'hFFF0, 3'b001);
    push_ld(0, 16'hFFF0, 3'b001);
    dn_q.push_back(4'b0001);
    clr_exp++;
    req = 4'b0001;
    @(negedge clk);
    chk("single_grant", grant, 4'b0001);
    wait_ren();
    repeat (2) @(negedge clk);
    pulse_int();
    wait_done();
    req = '0;
    @(negedge clk);
    chk("single_gnt_off", grant, 0);
    chk("single_done_off", done, 0);

    // reset asserted in WAIT (ptr now 1, so req[1] wins)
    set_req_cfg(1, 16'h0BAD, 3'd4);
    push_ld(1, 16'h0BAD, 3'd4);
    req = 4'b0010;
    wait_ren();
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_grant", grant, 0);
    chk("midrst_wen", tmr_wen, 0);
    chk("midrst_ren", tmr_ren, 0);
    chk("midrst_cfg", tmr_config_in, 0);
    chk("midrst_conf", tmr_timer_conf, 0);
    req = '0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_init_wen", tmr_wen, 1);
    chk("midrst_init_cfg", tmr_config_in, 8'h00);
    @(negedge clk);
    chk("midrst_idle_wen", tmr_wen, 0);

    // 3. round robin, all requests held (ptr reset to 0)
    for (int i = 0; i < NREQ; i++) set_req_cfg(i, rr_load[i], rr_presc[i]);
    for (int k = 0; k < 5; k++) begin
      push_ld(k % NREQ, rr_load[k % NREQ], rr_presc[k % NREQ]);
      dn_q.push_back(NREQ'(1) << (k % NREQ));
      clr_exp++;
    end
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_ren();
      repeat (2) @(negedge clk);
      pulse_int();
      wait_done();
    end
    req = '0;
    @(negedge clk);

    // 4. cancel: ptr=1, req[2] wins, then drops; req[3] is next
    push_ld(2, rr_load[2], rr_presc[2]);
    push_ld(3, rr_load[3], rr_presc[3]);
    dn_q.push_back(4'b1000);
    clr_exp += 2;
    req = 4'b1100;
    wait_ren();
    chk("cancel_grant", grant, 4'b0100);
    @(negedge clk);
    req = 4'b1000;
    @(negedge clk);
    chk("cancel_clr_cfg", tmr_config_in, 8'h00);
    chk("cancel_clr_wen", tmr_wen, 1);
    wait_ren();
    chk("cancel_next", grant, 4'b1000);
    repeat (2) @(negedge clk);
    pulse_int();
    wait_done();
    req = '0;
    @(negedge clk);

    // 5. collision: interrupt and req drop together, expiry wins (ptr=0)
    set_req_cfg(0, 16'h00AA, 3'd6);
    push_ld(0, 16'h00AA, 3'd6);
    dn_q.push_back(4'b0001);
    clr_exp++;
    req = 4'b0001;
    wait_ren();
    @(negedge clk);
    tmr_config_out = 8'h01;
    req = '0;
    @(negedge clk);
    tmr_config_out = 8'h00;
    wait_done();
    @(negedge clk);

`ifdef TSA_TIMEOUT_EN
    // 6. timeout: no interrupt, 20 WAIT cycles then err without done
    set_req_cfg(0, 16'h0055, 3'd1);
    push_ld(0, 16'h0055, 3'd1);
    clr_exp++;
    req = 4'b0001;
    wait_ren();
    wcnt = 0;
    while (tmr_ren && wcnt < 100) begin
      wcnt++;
      @(negedge clk);
    end
    chk("to_wait_cycles", wcnt, 20);
    @(negedge clk);
    chk("to_err", err, 1);
    chk("to_done", done, 0);
    req = '0;
    @(negedge clk);
    chk("to_err_off", err, 0);
`endif

    repeat (3) @(negedge clk);
    chk("ld_q_empty", ld_q.size(), 0);
    chk("dn_q_empty", dn_q.size(), 0);
    chk("clear_writes", n_clr, clr_exp);
    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
